// File: rtl/clock_monitor_pkg.sv
// Shared types and default parameters for the clock monitor.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } clkmon_state_t;

  localparam int DefCntWidth   = 25;
  localparam int DefTimeoutVal = 20002;
  localparam int DefTolerance  = 1;
  localparam int DefLockCount  = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the Clk domain and flags its edges.
// rise/fall are single-cycle pulses derived from the synchronised level and
// its one-cycle-old copy.
module sync_edge_detect (
  input  logic Clk,
  input  logic Rst_n,
  input  logic AsyncIn,
  output logic rise,
  output logic fall
);

  logic syncA;
  logic syncB;
  logic history;

  // Two-flop synchroniser followed by a history flop for edge comparison
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      syncA   <= 1'b0;
      syncB   <= 1'b0;
      history <= 1'b0;
    end else begin
      syncA   <= AsyncIn;
      syncB   <= syncA;
      history <= syncB;
    end
  end

  assign rise = syncB & ~history;
  assign fall = ~syncB & history;

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of an asynchronous clock in Clk cycles,
// tracks lock on a stable period and flags a lost input.
// Build option: define CLKMON_DUTY_EN to compile in high-time capture;
// without it HighTime is tied to zero.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CntWidth   = DefCntWidth,
  parameter int TimeoutVal = DefTimeoutVal,
  parameter int Tolerance  = DefTolerance,
  parameter int LockCount  = DefLockCount
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                ClkIn,
  input  logic                Clear,
  output logic [CntWidth-1:0] Period,
  output logic [CntWidth-1:0] HighTime,
  output logic                Valid,
  output logic                Locked,
  output logic                Timeout
);

  localparam int McW = (LockCount < 1) ? 1 : $clog2(LockCount + 1);
  localparam logic [CntWidth-1:0] TimeoutCmp = CntWidth'(TimeoutVal);
  localparam logic [CntWidth:0]   TolCmp     = (CntWidth + 1)'(Tolerance);
  localparam logic [McW-1:0]      LockCmp    = McW'(LockCount);

  clkmon_state_t state;
  clkmon_state_t nextState;

  logic                rise;
  logic                fall;
  logic [CntWidth-1:0] cycCnt;
  logic [CntWidth-1:0] cycCntInc;
  logic [McW-1:0]      matchCnt;
  logic                havePrev;
  logic                captureEn;
  logic                restartEn;
  logic                lostEn;
  logic [CntWidth:0]   newPeriodExt;
  logic [CntWidth:0]   oldPeriodExt;
  logic [CntWidth:0]   periodDiff;
  logic                periodMatch;

  sync_edge_detect edgeDetect (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .AsyncIn(ClkIn),
    .rise   (rise),
    .fall   (fall)
  );

  assign cycCntInc    = cycCnt + 1'b1;
  assign newPeriodExt = {1'b0, cycCntInc};
  assign oldPeriodExt = {1'b0, Period};
  assign periodDiff   = (newPeriodExt >= oldPeriodExt) ? (newPeriodExt - oldPeriodExt)
                                                       : (oldPeriodExt - newPeriodExt);
  assign periodMatch  = (periodDiff <= TolCmp);
  assign Locked       = (state == MEASURE) && (matchCnt == LockCmp);

  // State register; Clear forces a return to waiting for the first edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else if (Clear) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode plus the strobes that steer the result registers
  always_comb begin
    nextState = state;
    captureEn = 1'b0;
    restartEn = 1'b0;
    lostEn    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          nextState = MEASURE;
          restartEn = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          captureEn = 1'b1;
        end else if (cycCntInc == TimeoutCmp) begin
          nextState = LOST;
          lostEn    = 1'b1;
        end
      end
      LOST: begin
        if (rise) begin
          nextState = MEASURE;
          restartEn = 1'b1;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Free-running cycle counter, restarted on each rising edge, never wraps
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cycCnt <= '0;
    end else if (Clear) begin
      cycCnt <= '0;
    end else if (rise) begin
      cycCnt <= '0;
    end else if (cycCnt != '1) begin
      cycCnt <= cycCntInc;
    end
  end

  // Period capture, lock matching and loss flag; a restart forgets history
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Period   <= '0;
      Valid    <= 1'b0;
      Timeout  <= 1'b0;
      matchCnt <= '0;
      havePrev <= 1'b0;
    end else if (Clear) begin
      Period   <= '0;
      Valid    <= 1'b0;
      Timeout  <= 1'b0;
      matchCnt <= '0;
      havePrev <= 1'b0;
    end else begin
      Valid <= captureEn;
      if (captureEn) begin
        Period   <= cycCntInc;
        havePrev <= 1'b1;
        if (!havePrev) begin
          matchCnt <= '0;
        end else if (periodMatch) begin
          if (matchCnt != LockCmp) begin
            matchCnt <= matchCnt + 1'b1;
          end
        end else begin
          matchCnt <= '0;
        end
      end
      if (restartEn) begin
        Timeout  <= 1'b0;
        matchCnt <= '0;
        havePrev <= 1'b0;
      end
      if (lostEn) begin
        Timeout  <= 1'b1;
        matchCnt <= '0;
        havePrev <= 1'b0;
      end
    end
  end

`ifdef CLKMON_DUTY_EN
  logic [CntWidth-1:0] highHold;

  // High time latched on the fall, reported on the next rise; zero if no fall
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      highHold <= '0;
      HighTime <= '0;
    end else if (Clear) begin
      highHold <= '0;
      HighTime <= '0;
    end else begin
      if (rise) begin
        highHold <= '0;
      end else if (fall && (state == MEASURE)) begin
        highHold <= cycCntInc;
      end
      if (captureEn) begin
        HighTime <= highHold;
      end
    end
  end
`else
  logic unusedFallSink;
  assign unusedFallSink = fall;
  assign HighTime       = '0;
`endif

endmodule
